// File: rtl/dmem_responder.sv
// Data-memory responder for the 16-bit CPU load/store path.
// Accepts one word request at a time, waits a fixed access latency, performs
// the access, then presents the response until the requester consumes it.
//
//   state | meaning
//   IDLE  | ready for a request; req_ready_o high
//   WAIT  | request captured; counting down the access latency
//   RESP  | response presented; held until rsp_ready_i
module dmem_responder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-2:0] DEPTH_W = (ADDR_W-1)'(DEPTH);
    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        count;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-2:0] index;
    logic [IDX_W-1:0]  mem_idx;
    logic              err;
    logic              access;

    // The access decision is made from the captured request, never the live inputs.
    assign index   = addr_q[ADDR_W-1:1];
    assign mem_idx = index[IDX_W-1:0];
    assign err     = addr_q[0] | (index >= DEPTH_W);
    assign access  = (state == WAIT) && (count == 4'd0);

    // Storage array; no reset. A reset during WAIT forces IDLE, so the write never fires.
    always_ff @(posedge clk_i) begin
        if (access && write_q && !err) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    // Request/latency/response sequencing with registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        write_q     <= req_write_i;
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        count       <= COUNT_INIT;
                        req_ready_o <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        rsp_rdata_o <= (write_q || err) ? '0 : mem[mem_idx];
                        rsp_err_o   <= err;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: fixed vector table, directed multi-cycle
// sequences and randomized traffic checked against a word-array model.
module tb_dmem_responder;

    localparam int DEPTH = 128;
    localparam int LAT   = 2;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid_i, req_ready_o, req_write_i;
    logic [15:0] req_addr_i, req_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [15:0] rsp_rdata_o;

    logic        req_valid1, req_ready1, req_write1;
    logic [15:0] req_addr1, req_wdata1;
    logic        rsp_valid1, rsp_ready1, rsp_err1;
    logic [15:0] rsp_rdata1;

    always #5 clk_i = ~clk_i;

    dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
    );

    dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .LATENCY(1)) u_dut_lat1 (
        .clk_i(clk_i), .rst_n(rst_n),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_write_i(req_write1),
        .req_addr_i(req_addr1), .req_wdata_i(req_wdata1),
        .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1),
        .rsp_rdata_o(rsp_rdata1), .rsp_err_o(rsp_err1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model_mem   [DEPTH];
    bit          model_known [DEPTH];

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wd;
        logic        exp_err;
        logic [15:0] exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: an address is legal when even and its word index lies below DEPTH.
    task automatic model_apply(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                               output logic e_err, output logic [15:0] e_rd, output bit e_known);
        int idx;
        idx   = int'(addr) / 2;
        e_err = (addr % 2 != 0) || (idx >= DEPTH);
        if (e_err || wr) begin
            if (!e_err) begin
                model_mem[idx]   = wd;
                model_known[idx] = 1'b1;
            end
            e_rd    = 16'h0000;
            e_known = 1'b1;
        end else begin
            e_rd    = model_mem[idx];
            e_known = model_known[idx];
        end
    endtask

    // One full transaction from IDLE; hold = extra cycles with rsp_ready low.
    task automatic txn(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                       input int hold, input bit pulse,
                       output logic [15:0] rd, output logic er);
        int lat;
        check("req_ready_idle", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wd;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_write_i = 1'($urandom);
        req_addr_i  = 16'($urandom);
        req_wdata_i = 16'($urandom);
        lat = 0;
        while (!rsp_valid_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(LAT));
        rd = rsp_rdata_o;
        er = rsp_err_o;
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 1) begin
                req_valid_i = 1'b1;
                req_write_i = 1'b1;
                req_addr_i  = 16'h0040;
                req_wdata_i = 16'h9999;
            end
            @(posedge clk_i); #1;
            req_valid_i = 1'b0;
            check("hold_valid", 32'(rsp_valid_o), 32'd1);
            check("hold_rdata", 32'(rsp_rdata_o), 32'(rd));
            check("hold_err", 32'(rsp_err_o), 32'(er));
            check("hold_req_ready", 32'(req_ready_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid_o), 32'd0);
        check("err_clear", 32'(rsp_err_o), 32'd0);
        check("back_idle", 32'(req_ready_o), 32'd1);
        check("rdata_kept", 32'(rsp_rdata_o), 32'(rd));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [16];
        logic [15:0] rd, e_rd;
        logic        er, e_err;
        bit          e_known;
        int          acc [$];

        vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
        vecs[2]  = '{1'b0, 16'h0011, 16'h0000, 1'b1, 16'h0000};
        vecs[3]  = '{1'b1, 16'h0011, 16'h1234, 1'b1, 16'h0000};
        vecs[4]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
        vecs[5]  = '{1'b1, 16'h00FE, 16'hA5C3, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 16'h00FE, 16'h0000, 1'b0, 16'hA5C3};
        vecs[7]  = '{1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000};
        vecs[8]  = '{1'b1, 16'h0100, 16'h7777, 1'b1, 16'h0000};
        vecs[9]  = '{1'b0, 16'hFFFE, 16'h0000, 1'b1, 16'h0000};
        vecs[10] = '{1'b1, 16'h0000, 16'h0001, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0001};
        vecs[12] = '{1'b1, 16'h0040, 16'h1111, 1'b0, 16'h0000};
        vecs[13] = '{1'b1, 16'h0020, 16'h2222, 1'b0, 16'h0000};
        vecs[14] = '{1'b0, 16'h0020, 16'h0000, 1'b0, 16'h2222};
        vecs[15] = '{1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0000};

        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;

        req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        rsp_ready_i = 1'b0;
        req_valid1  = 1'b0; req_write1  = 1'b0; req_addr1  = '0; req_wdata1  = '0;
        rsp_ready1  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_req_ready", 32'(req_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rdata", 32'(rsp_rdata_o), 32'd0);
        check("rst_err", 32'(rsp_err_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk_i); #1;

        // Fixed vectors: alignment, top word, out of range
        foreach (vecs[i]) begin
            model_apply(vecs[i].wr, vecs[i].addr, vecs[i].wd, e_err, e_rd, e_known);
            txn(vecs[i].wr, vecs[i].addr, vecs[i].wd, 0, 1'b0, rd, er);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
        end

        // Response held for 5 cycles with a stray request pulsed in the middle
        model_apply(1'b1, 16'h0050, 16'h3C3C, e_err, e_rd, e_known);
        txn(1'b1, 16'h0050, 16'h3C3C, 5, 1'b1, rd, er);
        check("held_store_err", 32'(er), 32'd0);
        model_apply(1'b0, 16'h0040, 16'h0000, e_err, e_rd, e_known);
        txn(1'b0, 16'h0040, 16'h0000, 0, 1'b0, rd, er);
        check("stray_req_ignored", 32'(rd), 32'(e_rd));

        // Reset while a store sits in WAIT: store dropped, outputs back to reset values
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 16'h0020; req_wdata_i = 16'h5555;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready_o), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("midrst_rdata", 32'(rsp_rdata_o), 32'd0);
        check("midrst_err", 32'(rsp_err_o), 32'd0);
        @(posedge clk_i); #1;
        rst_n = 1'b1;
        @(posedge clk_i); #1;
        txn(1'b0, 16'h0020, 16'h0000, 0, 1'b0, rd, er);
        check("dropped_store", 32'(rd), 32'h2222);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            int          kind;
            bit          wr;
            logic [15:0] addr, wd;
            kind = int'($urandom_range(0, 9));
            wr   = 1'($urandom);
            wd   = 16'($urandom);
            if (kind < 7)       addr = 16'($urandom_range(0, 15) * 2 + 32'h80);
            else if (kind == 7) addr = 16'($urandom_range(0, 15) * 2 + 32'h81);
            else if (kind == 8) addr = 16'($urandom_range(256, 65535));
            else                addr = 16'h00FE;
            model_apply(wr, addr, wd, e_err, e_rd, e_known);
            txn(wr, addr, wd, int'($urandom_range(0, 2)), 1'b0, rd, er);
            check($sformatf("rand%0d_err", n), 32'(er), 32'(e_err));
            if (e_known) check($sformatf("rand%0d_rdata", n), 32'(rd), 32'(e_rd));
        end

        // LATENCY=1 instance, request and response ready held high
        req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 16'h0002; req_wdata1 = 16'h00AA;
        rsp_ready1 = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (req_ready1) acc.push_back(c);
            @(posedge clk_i); #1;
            if (rsp_valid1) check("lat1_err", 32'(rsp_err1), 32'd0);
        end
        req_valid1 = 1'b0;
        rsp_ready1 = 1'b0;
        check("lat1_accept_count", 32'(acc.size()), 32'd5);
        for (int i = 1; i < acc.size(); i++) begin
            check($sformatf("lat1_gap%0d", i), 32'(acc[i] - acc[i-1]), 32'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
